// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard inputs toward the controller, stage enables back.
// master = controller side, slave = pipeline datapath side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             IDEX_MemRead;
  logic             IDEX_RegWrite;
  logic [4:0]       IDEX_WriteReg;
  logic             EXMEM_Branch;
  logic             EXMEM_BranchCond;
  logic             EXMEM_MemRead;
  logic             EXMEM_MemWrite;
  logic             MemReady;

  logic             PCWrite;
  logic             PCSrcBranch;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Hold;
  logic             IDEX_Bubble;
  logic             EXMEM_Hold;
  logic             EXMEM_Flush;
  logic             MEMWB_Bubble;
  logic             MemTimeout;
  logic [1:0]       CtrlState;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg,
           EXMEM_Branch, EXMEM_BranchCond, EXMEM_MemRead, EXMEM_MemWrite, MemReady,
    output PCWrite, PCSrcBranch, IFID_Write, IFID_Flush, IDEX_Hold, IDEX_Bubble,
           EXMEM_Hold, EXMEM_Flush, MEMWB_Bubble, MemTimeout, CtrlState, StallCycles, FlushCount
  );

  modport slave (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg,
           EXMEM_Branch, EXMEM_BranchCond, EXMEM_MemRead, EXMEM_MemWrite, MemReady,
    input  PCWrite, PCSrcBranch, IFID_Write, IFID_Flush, IDEX_Hold, IDEX_Bubble,
           EXMEM_Hold, EXMEM_Flush, MEMWB_Bubble, MemTimeout, CtrlState, StallCycles, FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and slow-memory hazards,
// memory watchdog and saturating stall/flush counters. Stage controls are combinational.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic Clk,
  input  logic Reset,
  pipeline_hazard_ctrl_if.master hz
);
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  localparam logic [7:0] MaxWait8 = 8'(MAX_WAIT);

  state_t           state;
  logic [7:0]       waitCnt;
  logic             memTimeout;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  logic mw, br, lu, inError, stallNow, flushNow;

  always_comb begin
    mw = (hz.EXMEM_MemRead | hz.EXMEM_MemWrite) & ~hz.MemReady;
    br = hz.EXMEM_Branch & hz.EXMEM_BranchCond;
    lu = hz.IDEX_MemRead & hz.IDEX_RegWrite & (hz.IDEX_WriteReg != 5'd0) &
         ((hz.ID_UsesRs & (hz.ID_Rs == hz.IDEX_WriteReg)) |
          (hz.ID_UsesRt & (hz.ID_Rt == hz.IDEX_WriteReg)));
    inError  = (state == ERROR);
    // A load-use squashed by a taken branch never stalls, so it is not counted.
    stallNow = ~inError & (mw | (lu & ~br));
    flushNow = ~inError & br & ~mw;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= RUN;
      waitCnt    <= '0;
      memTimeout <= 1'b0;
      stallCnt   <= '0;
      flushCnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mw) begin
            state   <= MEM_WAIT;
            waitCnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mw) begin
            if (waitCnt == MaxWait8) begin
              state      <= ERROR;
              memTimeout <= 1'b1;
            end else begin
              waitCnt <= waitCnt + 8'd1;
            end
          end else begin
            state   <= RUN;
            waitCnt <= '0;
          end
        end
        ERROR:   state <= ERROR;
        default: state <= ERROR;
      endcase

      if (stallNow && (stallCnt != {CNT_W{1'b1}}))
        stallCnt <= stallCnt + 1'b1;
      if (flushNow && (flushCnt != {CNT_W{1'b1}}))
        flushCnt <= flushCnt + 1'b1;
    end
  end

  logic pcWrite, pcSrcBranch, ifidWrite, ifidFlush, idexHold, idexBubble;
  logic exmemHold, exmemFlush, memwbBubble;

  always_comb begin
    pcWrite     = 1'b0;
    pcSrcBranch = 1'b0;
    ifidWrite   = 1'b0;
    ifidFlush   = 1'b0;
    idexHold    = 1'b0;
    idexBubble  = 1'b0;
    exmemHold   = 1'b0;
    exmemFlush  = 1'b0;
    memwbBubble = 1'b0;
    if (Reset) begin
      ifidFlush   = 1'b1;
      idexBubble  = 1'b1;
      exmemFlush  = 1'b1;
      memwbBubble = 1'b1;
    end else if (inError || mw) begin
      // Freeze everything up to MEM; WB drains with a bubble behind the stalled access.
      idexHold    = 1'b1;
      exmemHold   = 1'b1;
      memwbBubble = 1'b1;
    end else if (br) begin
      pcWrite     = 1'b1;
      pcSrcBranch = 1'b1;
      ifidWrite   = 1'b1;
      ifidFlush   = 1'b1;
      idexBubble  = 1'b1;
      exmemFlush  = 1'b1;
    end else if (lu) begin
      idexBubble  = 1'b1;
    end else begin
      pcWrite     = 1'b1;
      ifidWrite   = 1'b1;
    end
  end

  assign hz.PCWrite      = pcWrite;
  assign hz.PCSrcBranch  = pcSrcBranch;
  assign hz.IFID_Write   = ifidWrite;
  assign hz.IFID_Flush   = ifidFlush;
  assign hz.IDEX_Hold    = idexHold;
  assign hz.IDEX_Bubble  = idexBubble;
  assign hz.EXMEM_Hold   = exmemHold;
  assign hz.EXMEM_Flush  = exmemFlush;
  assign hz.MEMWB_Bubble = memwbBubble;
  assign hz.MemTimeout   = memTimeout;
  assign hz.CtrlState    = state;
  assign hz.StallCycles  = stallCnt;
  assign hz.FlushCount   = flushCnt;
endmodule
